pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage sequencer that drives the PC register of the pipelined processor. It computes the next-PC value (`IF_Result`) and the PC enable. It handshakes with instruction memory and holds one pending redirect while a fetch is outstanding. It also generates stall and flush controls for the IF/ID pipeline register. It sits between the hazard unit, the ID-stage branch/jump resolution, exception logic and the PC register.

## Interface
- `RESET_VEC`, default 32'h0000_0000, first fetch address after reset
- `EXC_VEC`, default 32'h8000_0180, exception handler address

- `Clk`  in  1  clock; all state updates on rising edge
- `Clr`  in  1  asynchronous, active-high reset
- `IF_Addr`  in  32  current PC register output
- `Imem_Req`  out  1  fetch request to instruction memory at `IF_Addr`
- `Imem_Ack`  in  1  instruction valid for the current `IF_Addr` this cycle
- `Hz_Stall`  in  1  load-use stall from hazard unit
- `Br_Taken`  in  1  ID-stage taken branch
- `Br_Target`  in  32  branch target
- `Jmp`  in  1  ID-stage jump
- `Jmp_Target`  in  32  jump target
- `Exc`  in  1  exception request
- `IF_Result`  out  32  next-PC value, loaded by PC register
- `PC_En`  out  1  PC register load enable
- `IFID_Stall`  out  1  hold IF/ID register
- `IFID_Flush`  out  1  load bubble into IF/ID
- `Misalign`  out  1  misaligned redirect detected (see Configuration)

## Operation
- States: BOOT, RUN, PEND. Pending register: 32-bit target plus 2-bit priority tag.
- Redirect priority: `Exc` > `Jmp` > `Br_Taken`. Below is sequential PC+4.
- `Jmp` and `Br_Taken` are ignored while `Hz_Stall`=1. `Exc` is never masked.
- BOOT (one cycle after `Clr` deasserts):
  - `PC_En`=1, `IF_Result`=`RESET_VEC`, `Imem_Req`=0, `IFID_Flush`=1.
  - Next state RUN.
- RUN: `Imem_Req`=1.
  - Ack=1, no stall, no redirect: `PC_En`=1, `IF_Result`=`IF_Addr`+4.
  - Ack=1, redirect: `PC_En`=1, `IF_Result`=target, `IFID_Flush`=1.
  - `Hz_Stall`=1, no `Exc`: `PC_En`=0, `IFID_Stall`=1, `IFID_Flush`=0, regardless of Ack.
  - Ack=0, no redirect: `PC_En`=0, `IFID_Flush`=1 (bubble).
  - Ack=0, redirect: capture target and tag into the pending register, `IFID_Flush`=1, go to PEND.
- PEND: `Imem_Req`=1, `IFID_Flush`=1, `IFID_Stall`=0.
  - A new redirect with strictly higher priority than the tag overwrites the pending register. Equal or lower priority is dropped.
  - On Ack=1: `PC_En`=1, `IF_Result`=pending target (or the overriding target if one arrives the same cycle), clear the tag, return to RUN.
  - `Hz_Stall` is ignored in PEND.
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC gives 32'h0000_0000.

## Timing
- While `Clr`=1:
  - state=BOOT, pending cleared.
  - Outputs: `IF_Result`=`RESET_VEC`, `PC_En`=0, `Imem_Req`=0, `IFID_Stall`=0, `IFID_Flush`=1, `Misalign`=0.
- Output types:
  - `Imem_Req` is a function of state only.
  - All other outputs are combinational from state, pending register and current inputs (Mealy).
- Redirect latency:
  - A target presented with Ack=1 is in PC at the next edge. One flushed IF slot.
  - If buffered in PEND, the target is loaded on the Ack edge.
- `Clr` mid-PEND discards the pending redirect. BOOT follows.
- `Exc` and `Hz_Stall` in the same cycle: `Exc` wins, `PC_En`=1 if Ack, `IFID_Flush`=1, `IFID_Stall`=0.
- `Exc` in the same cycle as Ack=0 in RUN: go to PEND with tag=EXC.

## Configuration
- `PC_FETCH_CTRL_ALIGN_CHK_EN` defined:
  - Any accepted `Jmp`/`Br_Taken` target with bits [1:0]≠0 is replaced by `EXC_VEC` with exception priority.
  - `Misalign`=1 for that cycle.
  - Also applies when the misaligned target is captured into PEND (tag=EXC).
- Undefined: targets are used unchecked and `Misalign` is tied 0.

## Test plan
- Reset: hold `Clr` 3 cycles, release, Ack always 1 -> BOOT loads 32'h0, then `IF_Result` sequence 4, 8, C each cycle with `PC_En`=1.
- Load-use stall: `IF_Addr`=0x40, Ack=1, `Hz_Stall`=1 for 2 cycles with `Br_Taken`=1 -> `PC_En`=0, `IFID_Stall`=1, branch ignored, then `IF_Result`=0x44.
- Buffered redirect: Ack=0, `Br_Taken`=1/`Br_Target`=0x100, next cycle `Jmp`=1/`Jmp_Target`=0x200, Ack=1 two cycles later -> PEND, tag overwritten, `IF_Result`=0x200 on Ack, `IFID_Flush`=1 throughout PEND.
- Priority drop: in PEND with tag=EXC, `Jmp` asserted -> ignored, Ack loads `EXC_VEC` 0x80000180.
- Wrap: `IF_Addr`=0xFFFFFFFC, Ack=1 -> `IF_Result`=0x00000000.
- Alignment (macro on): Ack=1, `Br_Target`=0x102 -> `IF_Result`=0x80000180, `Misalign`=1. Macro off -> `IF_Result`=0x102, `Misalign`=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, imem handshake, one buffered redirect, IF/ID stall/flush.
// Optional alignment check of branch/jump targets enabled by defining PC_FETCH_CTRL_ALIGN_CHK_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IF_Addr,
    output logic        Imem_Req,
    input  logic        Imem_Ack,
    input  logic        Hz_Stall,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Target,
    input  logic        Jmp,
    input  logic [31:0] Jmp_Target,
    input  logic        Exc,
    output logic [31:0] IF_Result,
    output logic        PC_En,
    output logic        IFID_Stall,
    output logic        IFID_Flush,
    output logic        Misalign,
    output logic [1:0]  Dbg_State
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Tag encoding is ordered so a larger value means a higher-priority redirect.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_BR   = 2'd1,
        TAG_JMP  = 2'd2,
        TAG_EXC  = 2'd3
    } tag_t;

    state_t      state_q, state_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    tag_t        pend_tag_q, pend_tag_d;

    logic [31:0] seq_pc;
    logic        redir_mask;
    tag_t        req_tag;
    logic [31:0] req_tgt;
    logic        req_misalign;
    tag_t        eff_tag;
    logic [31:0] eff_tgt;

    // Highest-priority redirect offered this cycle; the load-use stall only masks it in RUN.
    always_comb begin
        seq_pc       = IF_Addr + 32'd4;
        redir_mask   = Hz_Stall && (state_q == RUN);
        req_tag      = TAG_NONE;
        req_tgt      = seq_pc;
        req_misalign = 1'b0;
        if (Exc) begin
            req_tag = TAG_EXC;
            req_tgt = EXC_VEC;
        end else if (Jmp && !redir_mask) begin
            req_tag = TAG_JMP;
            req_tgt = Jmp_Target;
        end else if (Br_Taken && !redir_mask) begin
            req_tag = TAG_BR;
            req_tgt = Br_Target;
        end
`ifdef PC_FETCH_CTRL_ALIGN_CHK_EN
        if ((req_tag == TAG_JMP || req_tag == TAG_BR) && (req_tgt[1:0] != 2'b00)) begin
            req_tag      = TAG_EXC;
            req_tgt      = EXC_VEC;
            req_misalign = 1'b1;
        end
`else
        req_misalign = 1'b0;
`endif
    end

    // Pending entry after a possible override by a strictly higher-priority request.
    always_comb begin
        eff_tag = pend_tag_q;
        eff_tgt = pend_tgt_q;
        if (req_tag > pend_tag_q) begin
            eff_tag = req_tag;
            eff_tgt = req_tgt;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pend_tag_d = pend_tag_q;
        Imem_Req   = (state_q != BOOT);
        PC_En      = 1'b0;
        IF_Result  = seq_pc;
        IFID_Stall = 1'b0;
        IFID_Flush = 1'b1;
        Misalign   = 1'b0;
        case (state_q)
            BOOT: begin
                PC_En     = 1'b1;
                IF_Result = RESET_VEC;
                state_d   = RUN;
            end
            RUN: begin
                Misalign = req_misalign;
                if (Hz_Stall && !Exc) begin
                    IFID_Stall = 1'b1;
                    IFID_Flush = 1'b0;
                end else if (req_tag != TAG_NONE) begin
                    IF_Result = req_tgt;
                    if (Imem_Ack) begin
                        PC_En = 1'b1;
                    end else begin
                        pend_tgt_d = req_tgt;
                        pend_tag_d = req_tag;
                        state_d    = PEND;
                    end
                end else begin
                    PC_En      = Imem_Ack;
                    IFID_Flush = !Imem_Ack;
                end
            end
            PEND: begin
                Misalign  = req_misalign;
                IF_Result = eff_tgt;
                if (Imem_Ack) begin
                    PC_En      = 1'b1;
                    pend_tag_d = TAG_NONE;
                    state_d    = RUN;
                end else begin
                    pend_tgt_d = eff_tgt;
                    pend_tag_d = eff_tag;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        // Reset overrides the Mealy outputs so the PC register is not loaded while Clr is high.
        if (Clr) begin
            PC_En      = 1'b0;
            IF_Result  = RESET_VEC;
            IFID_Stall = 1'b0;
            IFID_Flush = 1'b1;
            Misalign   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= BOOT;
            pend_tgt_q <= 32'h0;
            pend_tag_q <= TAG_NONE;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pend_tag_q <= pend_tag_d;
        end
    end

    assign Dbg_State = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0180;
`ifdef PC_FETCH_CTRL_ALIGN_CHK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] if_addr;
    logic        imem_req;
    logic        imem_ack;
    logic        hz_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic [31:0] if_result;
    logic        pc_en;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        misalign;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether the boot fetch has happened, and the buffered redirect.
    bit          m_booted;
    bit          m_pv;
    logic [31:0] m_pt;
    int          m_pp;
    bit          n_booted;
    bit          n_pv;
    logic [31:0] n_pt;
    int          n_pp;
    // Model outputs for the current cycle.
    logic [31:0] e_result;
    bit          e_pc_en, e_req, e_stall, e_flush, e_mis;

    pc_fetch_ctrl #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
        .Clk(clk), .Clr(clr), .IF_Addr(if_addr), .Imem_Req(imem_req), .Imem_Ack(imem_ack),
        .Hz_Stall(hz_stall), .Br_Taken(br_taken), .Br_Target(br_target), .Jmp(jmp),
        .Jmp_Target(jmp_target), .Exc(exc), .IF_Result(if_result), .PC_En(pc_en),
        .IFID_Stall(ifid_stall), .IFID_Flush(ifid_flush), .Misalign(misalign),
        .Dbg_State(dbg_state)
    );

    always #5 clk = ~clk;

    // Rules written as priorities: 3 = exception, 2 = jump, 1 = branch, 0 = none.
    function automatic void model_eval();
        int          pri;
        logic [31:0] tgt;
        logic [31:0] use_t;
        int          use_p;
        e_req = 0; e_stall = 0; e_flush = 1; e_mis = 0; e_pc_en = 0; e_result = RESET_VEC;
        n_booted = m_booted; n_pv = m_pv; n_pt = m_pt; n_pp = m_pp;
        if (clr) begin
            n_booted = 0; n_pv = 0; n_pp = 0;
        end else if (!m_booted) begin
            e_pc_en = 1; n_booted = 1;
        end else begin
            e_req = 1;
            pri = 0; tgt = 32'h0;
            if (exc) begin pri = 3; tgt = EXC_VEC; end
            else if (jmp && (!hz_stall || m_pv)) begin pri = 2; tgt = jmp_target; end
            else if (br_taken && (!hz_stall || m_pv)) begin pri = 1; tgt = br_target; end
            if (ALIGN_ON && (pri == 1 || pri == 2) && (tgt % 4 != 0)) begin
                pri = 3; tgt = EXC_VEC; e_mis = 1;
            end
            if (m_pv) begin
                use_t = (pri > m_pp) ? tgt : m_pt;
                use_p = (pri > m_pp) ? pri : m_pp;
                e_result = use_t;
                if (imem_ack) begin e_pc_en = 1; n_pv = 0; n_pp = 0; end
                else begin n_pt = use_t; n_pp = use_p; end
            end else if (hz_stall && !exc) begin
                e_flush = 0; e_stall = 1; e_result = if_addr + 32'd4;
            end else if (pri != 0) begin
                e_result = tgt; e_pc_en = imem_ack;
                if (!imem_ack) begin n_pv = 1; n_pt = tgt; n_pp = pri; end
            end else begin
                e_result = if_addr + 32'd4; e_pc_en = imem_ack; e_flush = !imem_ack;
            end
        end
    endfunction

    // Advance one clock; the bench plays the PC register, loading the model's next PC.
    task automatic tick();
        model_eval();
        @(posedge clk);
        m_booted = n_booted; m_pv = n_pv; m_pt = n_pt; m_pp = n_pp;
        if (e_pc_en) if_addr = e_result;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hz_stall = 0; br_taken = 0; jmp = 0; exc = 0;
    endtask

    task automatic test_reset();
        clr = 1; imem_ack = 1; if_addr = 32'h0; idle_inputs();
        br_target = 32'h0; jmp_target = 32'h0;
        m_booted = 0; m_pv = 0; m_pt = 0; m_pp = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (pc_en !== 1'b0 || imem_req !== 1'b0 || ifid_flush !== 1'b1 ||
                ifid_stall !== 1'b0 || if_result !== RESET_VEC || misalign !== 1'b0)
                $display("FAIL reset_hold: pc_en=%b req=%b flush=%b stall=%b result=%h mis=%b, want 0 0 1 0 %h 0",
                         pc_en, imem_req, ifid_flush, ifid_stall, if_result, misalign, RESET_VEC);
            if (pc_en !== 1'b0 || imem_req !== 1'b0 || ifid_flush !== 1'b1 ||
                ifid_stall !== 1'b0 || if_result !== RESET_VEC || misalign !== 1'b0) n_fail++;
            tick();
        end
        clr = 0;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== RESET_VEC || imem_req !== 1'b0 || ifid_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL boot: pc_en=%b result=%h req=%b flush=%b, want 1 %h 0 1",
                     pc_en, if_result, imem_req, ifid_flush, RESET_VEC);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_checks++;
            if (pc_en !== 1'b1 || if_result !== 32'(4 * i) || imem_req !== 1'b1 || ifid_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_pc%0d: pc_en=%b result=%h req=%b flush=%b, want 1 %h 1 0",
                         i, pc_en, if_result, imem_req, ifid_flush, 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_load_use_stall();
        if_addr = 32'h40; imem_ack = 1; hz_stall = 1; br_taken = 1; br_target = 32'h300;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (pc_en !== 1'b0 || ifid_stall !== 1'b1 || ifid_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: pc_en=%b stall=%b flush=%b, want 0 1 0", i, pc_en, ifid_stall, ifid_flush);
            end
            tick();
        end
        hz_stall = 0; br_taken = 0;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== 32'h44) begin
            n_fail++;
            $display("FAIL stall_release: pc_en=%b result=%h, want 1 00000044", pc_en, if_result);
        end
        tick();
    endtask

    task automatic test_buffered_redirect();
        imem_ack = 0; br_taken = 1; br_target = 32'h100;
        #1;
        n_checks++;
        if (pc_en !== 1'b0 || ifid_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL buf_capture: pc_en=%b flush=%b, want 0 1", pc_en, ifid_flush);
        end
        tick();
        br_taken = 0; jmp = 1; jmp_target = 32'h200;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (pc_en !== 1'b0 || ifid_flush !== 1'b1 || ifid_stall !== 1'b0 || imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL buf_pend%0d: pc_en=%b flush=%b stall=%b req=%b, want 0 1 0 1",
                         i, pc_en, ifid_flush, ifid_stall, imem_req);
            end
            tick();
            jmp = 0;
        end
        imem_ack = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== 32'h200 || ifid_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL buf_ack: pc_en=%b result=%h flush=%b, want 1 00000200 1", pc_en, if_result, ifid_flush);
        end
        tick();
    endtask

    task automatic test_priority_drop();
        imem_ack = 0; exc = 1;
        tick();
        exc = 0; jmp = 1; jmp_target = 32'h400;
        tick();
        imem_ack = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== EXC_VEC) begin
            n_fail++;
            $display("FAIL prio_drop: pc_en=%b result=%h, want 1 %h", pc_en, if_result, EXC_VEC);
        end
        tick();
        jmp = 0;
    endtask

    task automatic test_wrap();
        if_addr = 32'hFFFF_FFFC; imem_ack = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: pc_en=%b result=%h, want 1 00000000", pc_en, if_result);
        end
        tick();
    endtask

    task automatic test_alignment();
        logic [31:0] want_r;
        logic        want_m;
`ifdef PC_FETCH_CTRL_ALIGN_CHK_EN
        want_r = EXC_VEC; want_m = 1'b1;
`else
        want_r = 32'h102; want_m = 1'b0;
`endif
        imem_ack = 1; br_taken = 1; br_target = 32'h102;
        #1;
        n_checks++;
        if (if_result !== want_r || misalign !== want_m || pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL align: result=%h mis=%b pc_en=%b, want %h %b 1", if_result, misalign, pc_en, want_r, want_m);
        end
        tick();
        br_taken = 0; if_addr = 32'h1000;
    endtask

    task automatic test_exc_with_stall();
        imem_ack = 1; hz_stall = 1; exc = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== EXC_VEC || ifid_stall !== 1'b0 || ifid_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_stall: pc_en=%b result=%h stall=%b flush=%b, want 1 %h 0 1",
                     pc_en, if_result, ifid_stall, ifid_flush, EXC_VEC);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_clr_mid_pend();
        imem_ack = 0; jmp = 1; jmp_target = 32'h500;
        tick();
        jmp = 0; clr = 1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc_en !== 1'b0 || if_result !== RESET_VEC) begin
            n_fail++;
            $display("FAIL clr_pend: req=%b pc_en=%b result=%h, want 0 0 %h", imem_req, pc_en, if_result, RESET_VEC);
        end
        tick();
        clr = 0; imem_ack = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== RESET_VEC) begin
            n_fail++;
            $display("FAIL clr_reboot: pc_en=%b result=%h, want 1 %h", pc_en, if_result, RESET_VEC);
        end
        tick();
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || if_result !== 32'h4) begin
            n_fail++;
            $display("FAIL clr_discard: pc_en=%b result=%h, want 1 00000004", pc_en, if_result);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr        = ($urandom_range(0, 49) == 0);
            imem_ack   = ($urandom_range(0, 9) < 6);
            hz_stall   = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 9) < 3);
            jmp        = ($urandom_range(0, 9) < 2);
            exc        = ($urandom_range(0, 9) == 0);
            br_target  = $urandom() & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jmp_target = $urandom() & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            if ($urandom_range(0, 15) == 0) if_addr = 32'hFFFF_FFFC;
            #1;
            model_eval();
            n_checks++;
            if (if_result !== e_result || pc_en !== e_pc_en || imem_req !== e_req ||
                ifid_stall !== e_stall || ifid_flush !== e_flush || misalign !== e_mis) begin
                n_fail++;
                $display("FAIL rand%0d: res=%h en=%b req=%b st=%b fl=%b mis=%b, want %h %b %b %b %b %b",
                         i, if_result, pc_en, imem_req, ifid_stall, ifid_flush, misalign,
                         e_result, e_pc_en, e_req, e_stall, e_flush, e_mis);
            end
            tick();
        end
        clr = 0; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use_stall();
        test_buffered_redirect();
        test_priority_drop();
        test_wrap();
        test_alignment();
        test_exc_with_stall();
        test_clr_mid_pend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
